// File: rtl/opl_uart_sender.sv
// opl_uart_sender
//   Host side of the OPL2 serial register-write link. Register writes
//   (address, data) are queued in a FIFO and sent as two UART 8N1 frames,
//   address first, with no idle time between the two frames of a pair.
//   Pairs that are already waiting follow back-to-back. When the queue
//   drains, a fixed idle gap of GAP_BITS bit-times is sent. The far-end
//   end-of-packet detector uses this gap to reset its address/data toggle.
//   The same gap is sent after reset, so the far end re-aligns at power-up.
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   wr_valid    write request present
//   wr_ready    FIFO can accept a pair (registered); transfer on wr_valid & wr_ready
//   wr_addr     OPL register address, captured on the handshake cycle
//   wr_data     OPL register data, captured on the handshake cycle
//   tx          UART serial output, idle high (registered)
//   busy        high while the FIFO holds pairs or the sender is not idle
//   fifo_level  number of pairs currently stored
module opl_uart_sender #(
  parameter int unsigned CLK_HZ   = 25000000,
  parameter int unsigned BAUD     = 115200,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned GAP_BITS = 24
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [7:0]                   wr_addr,
  input  logic [7:0]                   wr_data,
  output logic                         tx,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level
);

  localparam int ACC_W = $clog2(CLK_HZ + BAUD);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int GAP_W = $clog2(GAP_BITS + 1);

  localparam logic [ACC_W:0]     BAUD_INC = (ACC_W+1)'(BAUD);
  localparam logic [ACC_W:0]     CLK_LIM  = (ACC_W+1)'(CLK_HZ);
  localparam logic [LVL_W-1:0]   LVL_FULL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0]   LVL_ONE  = LVL_W'(1);
  localparam logic [PTR_W-1:0]   PTR_ONE  = PTR_W'(1);
  localparam logic [GAP_W-1:0]   GAP_LOAD = GAP_W'(GAP_BITS);
  localparam logic [GAP_W-1:0]   GAP_ONE  = GAP_W'(1);

  localparam logic SEL_ADDR = 1'b0;
  localparam logic SEL_DATA = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  // ---------------------------------------------------------------------
  // Fractional baud generator: a tick fires on every clk where the
  // accumulator would reach CLK_HZ. The remainder is kept, so over a long
  // run the tick rate is exactly BAUD.
  // ---------------------------------------------------------------------
  logic [ACC_W-1:0] acc_r;
  logic [ACC_W:0]   acc_sum_s;
  logic             tick_s;

  // Next accumulator value and tick decision
  always_comb begin
    acc_sum_s = {1'b0, acc_r} + BAUD_INC;
    tick_s    = (acc_sum_s >= CLK_LIM);
  end

  // Free-running accumulator; only rst_n clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= '0;
    end else if (tick_s) begin
      acc_r <= ACC_W'(acc_sum_s - CLK_LIM);
    end else begin
      acc_r <= acc_sum_s[ACC_W-1:0];
    end
  end

  // ---------------------------------------------------------------------
  // Pair FIFO
  // ---------------------------------------------------------------------
  logic [7:0]       addr_mem_r [DEPTH];
  logic [7:0]       data_mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [LVL_W-1:0] level_r;
  logic [LVL_W-1:0] level_nxt_s;
  logic             wr_ready_r;
  logic             push_s;
  logic             pop_s;
  logic             empty_s;

  // Handshake and occupancy for the coming edge
  always_comb begin
    push_s  = wr_valid & wr_ready_r;
    empty_s = (level_r == '0);
    case ({push_s, pop_s})
      2'b10:   level_nxt_s = level_r + LVL_ONE;
      2'b01:   level_nxt_s = level_r - LVL_ONE;
      default: level_nxt_s = level_r;
    endcase
  end

  // Storage and pointers; reset flushes the queue. Pointers wrap because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        addr_mem_r[i] <= 8'h00;
        data_mem_r[i] <= 8'h00;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (push_s) begin
        addr_mem_r[wr_ptr_r] <= wr_addr;
        data_mem_r[wr_ptr_r] <= wr_data;
        wr_ptr_r             <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      level_r <= level_nxt_s;
    end
  end

  // ---------------------------------------------------------------------
  // Serialiser FSM. State changes and tx updates happen only on tick cycles.
  // ---------------------------------------------------------------------
  state_t           state_r;
  state_t           state_nxt;
  logic             tx_r;
  logic             tx_nxt;
  logic [2:0]       bit_r;
  logic [2:0]       bit_nxt;
  logic             sel_r;
  logic             sel_nxt;
  logic [GAP_W-1:0] gap_r;
  logic [GAP_W-1:0] gap_nxt;
  logic [7:0]       sh_addr_r;
  logic [7:0]       sh_data_r;
  logic [7:0]       cur_byte_s;
  logic             busy_r;
  logic             busy_nxt;
  logic             wr_ready_nxt;

  // Byte currently on the wire
  always_comb begin
    if (sel_r == SEL_DATA) begin
      cur_byte_s = sh_data_r;
    end else begin
      cur_byte_s = sh_addr_r;
    end
  end

  // Next-state, next-tx and pop decision
  always_comb begin
    state_nxt = state_r;
    tx_nxt    = tx_r;
    bit_nxt   = bit_r;
    sel_nxt   = sel_r;
    gap_nxt   = gap_r;
    pop_s     = 1'b0;
    if (tick_s) begin
      case (state_r)
        ST_IDLE: begin
          if (!empty_s) begin
            pop_s     = 1'b1;
            sel_nxt   = SEL_ADDR;
            state_nxt = ST_START;
            tx_nxt    = 1'b0;
          end else begin
            tx_nxt    = 1'b1;
          end
        end
        ST_START: begin
          state_nxt = ST_DATA;
          bit_nxt   = 3'd0;
          tx_nxt    = cur_byte_s[0];
        end
        ST_DATA: begin
          if (bit_r == 3'd7) begin
            state_nxt = ST_STOP;
            tx_nxt    = 1'b1;
          end else begin
            bit_nxt   = bit_r + 3'd1;
            tx_nxt    = cur_byte_s[bit_r + 3'd1];
          end
        end
        ST_STOP: begin
          // The data frame always follows its address frame directly, so a
          // gap can only be inserted between pairs.
          if (sel_r == SEL_ADDR) begin
            sel_nxt   = SEL_DATA;
            state_nxt = ST_START;
            tx_nxt    = 1'b0;
          end else if (!empty_s) begin
            pop_s     = 1'b1;
            sel_nxt   = SEL_ADDR;
            state_nxt = ST_START;
            tx_nxt    = 1'b0;
          end else begin
            state_nxt = ST_GAP;
            gap_nxt   = GAP_LOAD;
            tx_nxt    = 1'b1;
          end
        end
        ST_GAP: begin
          tx_nxt = 1'b1;
          if (gap_r <= GAP_ONE) begin
            state_nxt = ST_IDLE;
            gap_nxt   = '0;
          end else begin
            gap_nxt   = gap_r - GAP_ONE;
          end
        end
        default: begin
          state_nxt = ST_GAP;
          gap_nxt   = GAP_LOAD;
          tx_nxt    = 1'b1;
        end
      endcase
    end else begin
      state_nxt = state_r;
    end
  end

  // Registered status outputs: compute their next values from the next state
  always_comb begin
    busy_nxt     = (state_nxt != ST_IDLE) || (level_nxt_s != '0);
    wr_ready_nxt = (level_nxt_s != LVL_FULL);
  end

  // FSM and output registers. Reset restarts the re-alignment gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_GAP;
      tx_r       <= 1'b1;
      bit_r      <= 3'd0;
      sel_r      <= SEL_ADDR;
      gap_r      <= GAP_LOAD;
      busy_r     <= 1'b1;
      wr_ready_r <= 1'b0;
    end else begin
      state_r    <= state_nxt;
      tx_r       <= tx_nxt;
      bit_r      <= bit_nxt;
      sel_r      <= sel_nxt;
      gap_r      <= gap_nxt;
      busy_r     <= busy_nxt;
      wr_ready_r <= wr_ready_nxt;
    end
  end

  // Shift registers load the head pair on each pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_addr_r <= 8'h00;
      sh_data_r <= 8'h00;
    end else if (pop_s) begin
      sh_addr_r <= addr_mem_r[rd_ptr_r];
      sh_data_r <= data_mem_r[rd_ptr_r];
    end else begin
      sh_addr_r <= sh_addr_r;
      sh_data_r <= sh_data_r;
    end
  end

  assign tx         = tx_r;
  assign busy       = busy_r;
  assign wr_ready   = wr_ready_r;
  assign fifo_level = level_r;

endmodule

// File: tb/tb_opl_uart_sender.sv
// Bench for opl_uart_sender: 10 clk per bit, 24-bit gap, 16-pair FIFO.
// A far-end receiver model decodes tx into 8N1 bytes and pairs them with an
// address/data toggle. The toggle is reset by long idle periods. Decoded
// pairs are checked against a queue of the pairs accepted at the write port.
module tb_opl_uart_sender;

  localparam int unsigned CLK_HZ   = 1152000;
  localparam int unsigned BAUD     = 115200;
  localparam int unsigned DEPTH    = 16;
  localparam int unsigned GAP_BITS = 24;
  localparam int CLK_PER_BIT = 10;
  localparam int GAP_CLK     = 240;
  localparam int EOP_CLK     = 200;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       tx;
  logic       busy;
  logic [4:0] fifo_level;

  opl_uart_sender #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH(DEPTH), .GAP_BITS(GAP_BITS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .tx(tx), .busy(busy),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- far-end receiver model ----------------
  bit         rx_active = 1'b0;
  int         rx_cnt = 0;
  logic       rx_first;
  bit         rx_stable;
  logic [7:0] rx_byte;
  logic [7:0] rx_addr;
  int         idle_cnt = 0;
  bit         prev_ended = 1'b0;
  bit         tog_data = 1'b0;
  int         rx_pairs = 0;
  int         rx_frames = 0;
  int         last_idle = 0;
  int         run_len = 0;
  int         max_run = 0;

  initial begin
    int k;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        rx_active  = 1'b0;
        idle_cnt   = 0;
        prev_ended = 1'b0;
        tog_data   = 1'b0;
      end else begin
        if (!rx_active) begin
          if (tx === 1'b0) begin
            rx_frames++;
            if (idle_cnt == 0) begin
              check_eq("gap_before_frame", prev_ended, 1'b1);
              run_len++;
            end else begin
              check_eq($sformatf("gap_len=%0d>=%0d", idle_cnt, GAP_CLK), idle_cnt >= GAP_CLK, 1'b1);
              last_idle = idle_cnt;
              if (idle_cnt >= EOP_CLK) begin
                check_eq("pair_split", tog_data, 1'b0);
                tog_data = 1'b0;
              end
              run_len = 1;
            end
            if (run_len > max_run) max_run = run_len;
            rx_active = 1'b1;
            rx_cnt    = 0;
          end else begin
            idle_cnt++;
          end
        end
        if (rx_active) begin
          if (rx_cnt % CLK_PER_BIT == 0) begin
            rx_first  = tx;
            rx_stable = 1'b1;
          end else if (tx !== rx_first) begin
            rx_stable = 1'b0;
          end
          if (rx_cnt % CLK_PER_BIT == CLK_PER_BIT - 1) begin
            k = rx_cnt / CLK_PER_BIT;
            check_eq($sformatf("bit%0d_stable", k), rx_stable, 1'b1);
            if (k >= 1 && k <= 8) begin
              rx_byte[k-1] = rx_first;
            end else if (k == 9) begin
              check_eq("stop_bit", rx_first, 1'b1);
              rx_active  = 1'b0;
              prev_ended = 1'b1;
              idle_cnt   = 0;
              if (!tog_data) begin
                rx_addr  = rx_byte;
                tog_data = 1'b1;
              end else begin
                tog_data = 1'b0;
                rx_pairs++;
                if (exp_q.size() == 0) check_eq("pair_extra", exp_q.size(), 1);
                else check_eq("pair", {rx_addr, rx_byte}, exp_q.pop_front());
              end
            end
          end
          rx_cnt++;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called at a negedge; returns at a negedge after the handshake.
  task automatic push_pair(input logic [7:0] a, input logic [7:0] d, input int max_wait, output int waited);
    bit ok;
    ok = 1'b0;
    waited = 0;
    wr_addr = a; wr_data = d; wr_valid = 1'b1;
    while (!ok && waited < max_wait) begin
      if (wr_ready === 1'b1) begin
        @(posedge clk);
        exp_q.push_back({a, d});
        ok = 1'b1;
        @(negedge clk);
      end else begin
        @(negedge clk);
        waited++;
      end
    end
    wr_valid = 1'b0;
    check_eq("push_accepted", ok, 1'b1);
  endtask

  task automatic wait_busy_low(input string tag, input int max_cyc, output int n);
    n = 0;
    while (busy === 1'b1 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, busy, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    check_eq("rst_tx", tx, 1'b1);
    check_eq("rst_busy", busy, 1'b1);
    check_eq("rst_level", fifo_level, 5'd0);
    check_eq("rst_ready", wr_ready, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int n, w, base;
    logic [7:0] a, d;
    rst_n = 1'b0; wr_valid = 1'b0; wr_addr = 8'h00; wr_data = 8'h00;

    // 1: reset gap with no writes
    do_reset();
    @(negedge clk);
    check_eq("t1_ready_after_rst", wr_ready, 1'b1);
    wait_busy_low("t1_busy_falls", 400, n);
    check_eq($sformatf("t1_busy_len=%0d in[235,250]", n), (n >= 235 && n <= 250), 1'b1);
    check_eq("t1_no_frames", rx_frames, 0);

    // 2: single pair A0/41 from idle
    base = rx_pairs;
    push_pair(8'hA0, 8'h41, 20, w);
    check_eq("t2_busy_high", busy, 1'b1);
    wait_busy_low("t2_busy_falls", 700, n);
    check_eq($sformatf("t2_busy_len=%0d in[440,452]", n), (n >= 440 && n <= 452), 1'b1);
    check_eq("t2_pairs", rx_pairs, base + 1);
    check_eq("t2_queue_empty", exp_q.size(), 0);

    // 4: a write arriving during the gap waits for the full gap
    base = rx_pairs;
    push_pair(8'($urandom), 8'($urandom), 20, w);
    n = 0;
    while (rx_pairs != base + 1 && n < 600) begin @(negedge clk); n++; end
    check_eq("t4_first_pair", rx_pairs, base + 1);
    repeat (60) @(negedge clk);
    push_pair(8'($urandom), 8'($urandom), 20, w);
    wait_busy_low("t4_busy_falls", 1200, n);
    check_eq("t4_pairs", rx_pairs, base + 2);
    check_eq($sformatf("t4_idle=%0d in[240,250]", last_idle), (last_idle >= 240 && last_idle <= 250), 1'b1);

    // 3: fill FIFO during the reset gap
    do_reset();
    max_run = 0; run_len = 0;
    base = rx_pairs;
    for (int i = 0; i < 16; i++) begin
      push_pair(8'($urandom), 8'($urandom), 4, w);
    end
    check_eq("t3_ready_low_full", wr_ready, 1'b0);
    check_eq("t3_level_full", fifo_level, 5'd16);
    push_pair(8'($urandom), 8'($urandom), 400, w);
    check_eq($sformatf("t3_held=%0d in[200,250]", w), (w >= 200 && w <= 250), 1'b1);
    wait_busy_low("t3_busy_falls", 6000, n);
    check_eq("t3_pairs", rx_pairs, base + 17);
    check_eq("t3_contiguous_frames", max_run, 34);

    // 5: reset in the middle of an address byte
    push_pair(8'h00, 8'h5A, 20, w);
    push_pair(8'h3C, 8'hC3, 20, w);
    n = 0;
    while (!rx_active && n < 30) begin @(negedge clk); n++; end
    check_eq("t5_started", rx_active, 1'b1);
    check_eq("t5_level_one", fifo_level, 5'd1);
    repeat (30) @(negedge clk);
    check_eq("t5_tx_low_pre", tx, 1'b0);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_eq("t5_tx_async", tx, 1'b1);
    check_eq("t5_level_flushed", fifo_level, 5'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base = rx_pairs;
    push_pair(8'h12, 8'h34, 20, w);
    wait_busy_low("t5_busy_falls", 1500, n);
    check_eq("t5_pairs", rx_pairs, base + 1);
    check_eq("t5_queue_empty", exp_q.size(), 0);

    // 6: random pair stream with random pauses
    base = rx_pairs;
    for (int i = 0; i < 40; i++) begin
      int r, pause;
      a = 8'($urandom);
      d = 8'($urandom);
      push_pair(a, d, 600, w);
      r = $urandom_range(0, 9);
      if (r < 5) pause = 0;
      else if (r < 8) pause = $urandom_range(1, 150);
      else pause = $urandom_range(250, 450);
      repeat (pause) @(negedge clk);
    end
    wait_busy_low("t6_busy_falls", 12000, n);
    check_eq("t6_pairs", rx_pairs, base + 40);
    check_eq("t6_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
